// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module   : instruction_loader
// Brief    : Boot-time loader that assembles a big-endian byte stream into
//            32-bit instruction words, writes them to instruction memory and
//            verifies a trailing XOR checksum byte.
// Revision : 1.0
// ============================================================================
module instruction_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [8:0]  length,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [8:0] c_max_len = 9'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_q,      state_d;
    logic [8:0]  len_q,        len_d;
    logic [8:0]  word_idx_q,   word_idx_d;
    logic [1:0]  byte_idx_q,   byte_idx_d;
    logic [7:0]  acc_q,        acc_d;
    logic [23:0] word_q,       word_d;
    logic        byte_ready_q, byte_ready_d;
    logic        mem_we_q,     mem_we_d;
    logic [31:0] mem_addr_q,   mem_addr_d;
    logic [31:0] mem_wdata_q,  mem_wdata_d;
    logic        busy_q,       busy_d;
    logic        done_q,       done_d;
    logic        error_q,      error_d;

    logic        w_fire;
    logic [8:0]  w_len_clamped;
    logic [8:0]  w_next_idx;

    assign w_fire        = byte_valid && byte_ready_q;
    assign w_len_clamped = (length > c_max_len) ? c_max_len : length;
    assign w_next_idx    = word_idx_q + 9'd1;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        acc_d        = acc_q;
        word_d       = word_q;
        byte_ready_d = byte_ready_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    len_d      = w_len_clamped;
                    word_idx_d = 9'd0;
                    byte_idx_d = 2'd0;
                    acc_d      = 8'd0;
                    error_d    = 1'b0;
                    if (w_len_clamped == 9'd0) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        busy_d       = 1'b0;
                        byte_ready_d = 1'b0;
                    end else begin
                        state_d      = RECV;
                        done_d       = 1'b0;
                        busy_d       = 1'b1;
                        byte_ready_d = 1'b1;
                    end
                end
            end
            RECV: begin
                if (w_fire) begin
                    // Shift in MSB-first so the first byte lands in [31:24]
                    word_d     = {word_q[15:0], byte_in};
                    acc_d      = acc_q ^ byte_in;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d      = WRITE;
                        byte_ready_d = 1'b0;
                        mem_we_d     = 1'b1;
                        mem_addr_d   = BASE_ADDR + {23'd0, word_idx_q};
                        mem_wdata_d  = {word_q, byte_in};
                    end
                end
            end
            WRITE: begin
                word_idx_d   = w_next_idx;
                byte_ready_d = 1'b1;
                state_d      = (w_next_idx == len_q) ? CHECK : RECV;
            end
            CHECK: begin
                if (w_fire) begin
                    error_d      = (byte_in != acc_q);
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    byte_ready_d = 1'b0;
                    state_d      = DONE;
                end
            end
            default: begin
                state_d      = IDLE;
                byte_ready_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            len_q        <= 9'd0;
            word_idx_q   <= 9'd0;
            byte_idx_q   <= 2'd0;
            acc_q        <= 8'd0;
            word_q       <= 24'd0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            acc_q        <= acc_d;
            word_q       <= word_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_loader
// Brief    : Scoreboard bench for instruction_loader with randomized streams.
// Revision : 1.0
// ============================================================================
module tb_instruction_loader;

    localparam logic [31:0] BASE = 32'd0;
    localparam int          MAXW = 256;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  length = 9'd0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;

    instruction_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .length     (length),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          fires = 0;
    bit          stall_en = 1'b0;
    logic [7:0]  src_q[$];
    logic [31:0] plan_q[$];
    wr_t         exp_wr[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte source: offers the head of src_q, optionally with random gaps
    initial begin
        forever begin
            @(posedge clock);
            if (byte_valid && byte_ready && src_q.size() > 0) begin
                void'(src_q.pop_front());
                fires++;
            end
            #1;
            if (src_q.size() > 0 && (!stall_en || $urandom_range(1, 0) == 1)) begin
                byte_valid = 1'b1;
                byte_in    = src_q[0];
            end else begin
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
            end
        end
    end

    // Write monitor: every mem_we pulse must match the next expected write
    always @(negedge clock) begin
        wr_t e;
        if (reset_n && mem_we) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, no write expected", mem_addr, mem_wdata);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", {32'd0, mem_addr}, {32'd0, e.addr});
                chk("wr_data", {32'd0, mem_wdata}, {32'd0, e.data});
            end
        end
    end

    // ck_mode: 0 correct checksum, 1 corrupted checksum, 2 explicit ck_val
    task automatic do_load(input int len_in, input int ck_mode, input logic [7:0] ck_val,
                           input bit mid_start);
        int          n;
        logic [7:0]  acc;
        logic [7:0]  ck;
        logic [7:0]  b;
        logic [31:0] w;
        int          f0;
        int          s_cyc;
        int          d_cyc;
        bit          got;
        n   = (len_in > MAXW) ? MAXW : len_in;
        acc = 8'd0;
        for (int i = 0; i < n; i++) begin
            if (plan_q.size() > 0) w = plan_q.pop_front();
            else                   w = $urandom;
            exp_wr.push_back({BASE + 32'(i), w});
            for (int k = 0; k < 4; k++) begin
                b = 8'(w >> (24 - 8 * k));
                src_q.push_back(b);
                acc ^= b;
            end
        end
        case (ck_mode)
            0:       ck = acc;
            1:       ck = acc ^ 8'($urandom_range(255, 1));
            default: ck = ck_val;
        endcase
        if (n > 0) src_q.push_back(ck);
        f0 = fires;

        @(posedge clock); #1;
        start  = 1'b1;
        length = 9'(len_in);
        @(posedge clock); #1;
        start = 1'b0;
        s_cyc = cyc;
        if (n > 0) begin
            chk("start_busy", {63'd0, busy}, 64'd1);
            chk("start_ready", {63'd0, byte_ready}, 64'd1);
            chk("start_done_clr", {63'd0, done}, 64'd0);
            chk("start_err_clr", {63'd0, error}, 64'd0);
        end else begin
            chk("len0_done", {63'd0, done}, 64'd1);
            chk("len0_busy", {63'd0, busy}, 64'd0);
            chk("len0_ready", {63'd0, byte_ready}, 64'd0);
            chk("len0_error", {63'd0, error}, 64'd0);
        end

        got   = 1'b0;
        d_cyc = s_cyc;
        for (int k = 0; k < 30000 && !got; k++) begin
            if (done) begin
                got   = 1'b1;
                d_cyc = cyc;
            end else begin
                @(posedge clock); #1;
                start = (mid_start && k == 10);
                if (start) length = 9'd1;
            end
        end
        start = 1'b0;

        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done still 0 after 30000 cycles, required 1");
        end else begin
            chk("error", {63'd0, error}, {63'd0, (ck != acc)});
            chk("done_busy", {63'd0, busy}, 64'd0);
            chk("done_ready", {63'd0, byte_ready}, 64'd0);
            chk("bytes_taken", 64'(fires - f0), (n > 0) ? 64'(4 * n + 1) : 64'd0);
            chk("writes_left", 64'(exp_wr.size()), 64'd0);
            if (!stall_en)
                chk("latency", 64'(d_cyc - s_cyc), (n > 0) ? 64'(5 * n + 1) : 64'd0);
            if (n > 0)
                chk("bytes_left", 64'(src_q.size()), 64'd0);
        end
    endtask

    task automatic reset_midload();
        logic [31:0] w0;
        logic [31:0] w1;
        int          f0;
        w0 = $urandom;
        w1 = $urandom;
        exp_wr.push_back({BASE, w0});
        for (int k = 0; k < 4; k++) src_q.push_back(8'(w0 >> (24 - 8 * k)));
        for (int k = 0; k < 2; k++) src_q.push_back(8'(w1 >> (24 - 8 * k)));
        f0 = fires;
        @(posedge clock); #1;
        start  = 1'b1;
        length = 9'd4;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 0; k < 200 && (fires - f0) < 6; k++) begin
            @(posedge clock); #1;
        end
        chk("rst_bytes_taken", 64'(fires - f0), 64'd6);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_ready", {63'd0, byte_ready}, 64'd0);
        chk("rst_we", {63'd0, mem_we}, 64'd0);
        chk("rst_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_word0_written", 64'(exp_wr.size()), 64'd0);
        src_q.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_ready", {63'd0, byte_ready}, 64'd0);
        chk("reset_we", {63'd0, mem_we}, 64'd0);
        chk("reset_addr", {32'd0, mem_addr}, 64'd0);
        chk("reset_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_error", {63'd0, error}, 64'd0);
        reset_n = 1'b1;

        plan_q = {32'h12345678};
        do_load(1, 2, 8'h08, 1'b0);
        plan_q = {32'h11223344, 32'hAABBCCDD};
        do_load(2, 2, 8'h00, 1'b0);
        plan_q = {32'h11223344, 32'hAABBCCDD};
        do_load(2, 0, 8'h00, 1'b0);

        stall_en = 1'b1;
        do_load(3, 0, 8'h00, 1'b0);
        do_load(3, 1, 8'h00, 1'b0);
        stall_en = 1'b0;

        // Zero-length load: offered bytes must stay untouched
        src_q = {8'hA5, 8'h5A};
        do_load(0, 0, 8'h00, 1'b0);
        repeat (3) begin
            @(posedge clock); #1;
            chk("len0_ready_low", {63'd0, byte_ready}, 64'd0);
        end
        chk("len0_src_intact", 64'(src_q.size()), 64'd2);
        src_q.delete();

        do_load(300, 0, 8'h00, 1'b0);

        reset_midload();
        do_load(4, 0, 8'h00, 1'b0);
        do_load(4, 0, 8'h00, 1'b1);
        do_load(5, 1, 8'h00, 1'b0);
        do_load(2, 0, 8'h00, 1'b0);

        repeat (4) begin
            stall_en = ($urandom_range(1, 0) == 1);
            do_load(int'($urandom_range(8, 1)), int'($urandom_range(1, 0)), 8'h00, 1'b0);
        end
        stall_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_loader.md
# instruction_loader

Boot-time writer for the instruction memory. It receives a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It drives the memory's write port at consecutive word addresses, then checks a trailing XOR checksum byte. It sits between the host/debug link and the instruction memory, and holds `busy` high so the processor stays stalled until the load finishes.

## Interface
- `BASE_ADDR`, 0: word address of the first instruction written.
- `MAX_WORDS`, 256: instruction memory depth in words; `length` is clamped to this value.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle pulse that begins a load. Sampled only in IDLE or DONE.
- `length` input 9: number of instruction words (0..256), latched on an accepted `start`.
- `byte_in` input 8: stream data byte.
- `byte_valid` input 1: `byte_in` is valid.
- `byte_ready` output 1: the loader accepts a byte this cycle.
- `mem_we` output 1: instruction memory write enable, one-cycle pulse per word.
- `mem_addr` output 32: word address, equal to `BASE_ADDR` + word index, zero-extended (same word addressing as the fetch AddressBus).
- `mem_wdata` output 32: assembled instruction word.
- `busy` output 1: high from an accepted `start` until DONE is entered.
- `done` output 1: load complete; held high until the next accepted `start`.
- `error` output 1: checksum mismatch; valid while `done`=1.

## Operation
- The FSM has five states: IDLE, RECV, WRITE, CHECK, DONE.
- **IDLE/DONE → accepted start:**
  - Latch `len` = min(`length`, `MAX_WORDS`).
  - Clear word index, byte index, XOR accumulator, `done` and `error`.
  - If `len`=0, go to DONE with `error`=0 and consume no bytes. Otherwise set `busy`=1 and go to RECV.
- **RECV:**
  - `byte_ready`=1. A byte is transferred only on an edge where `byte_valid` and `byte_ready` are both 1.
  - Byte index 0 goes to bits [31:24], 1 to [23:16], 2 to [15:8], 3 to [7:0]. The Function field therefore arrives first.
  - Each accepted byte is XORed into the accumulator.
  - When byte index 3 is accepted, go to WRITE. The byte index wraps to 0.
- **WRITE (exactly one cycle):**
  - `mem_we`=1, `mem_addr`=`BASE_ADDR`+index, `mem_wdata`=assembled word, `byte_ready`=0.
  - Next, the index increments. If the new index equals `len`, go to CHECK; otherwise go to RECV.
- **CHECK:**
  - `byte_ready`=1. Accept one byte.
  - `error` = (byte ≠ accumulator). Go to DONE, with `busy`=0 and `done`=1.
- **DONE:** `byte_ready`=0. Holds all results until the next `start`.
- `start` is ignored while `busy`=1; no restart mid-load.
- A byte offered while `byte_ready`=0 is not consumed. The source must hold it.
- The word index is 9 bits wide, so `len`=256 terminates correctly. `mem_addr` arithmetic is 32-bit and wraps modulo 2^32.
- **Reset (any time, including mid-load):**
  - Outputs return to reset values and the FSM returns to IDLE.
  - Words already written stay in memory; nothing is rolled back.

## Timing
- Reset values: `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0. FSM in IDLE.
- Outputs are registered (Moore) and derive from state only. `byte_ready` does not depend combinationally on `byte_valid`.
- Accepted `start` at edge N: `busy`=1 and `byte_ready`=1 from cycle N+1.
- Per word with `byte_valid` held high: 4 accept cycles plus 1 WRITE cycle, i.e. 5 cycles per word.
- `mem_we` rises the cycle after the 4th byte is accepted. `mem_addr` and `mem_wdata` are stable during that cycle and hold afterwards until the next write.
- Checksum byte accepted at edge M: `done`/`error` valid and `busy`=0 from cycle M+1.
- Full load latency with no stalls: 1 + 5·`len` + 1 cycles from `start` to `done`.
- `start` and `byte_valid` in the same cycle in IDLE: only `start` acts, because `byte_ready`=0 in IDLE.

## Test plan
- Load `len`=1, bytes 12 34 56 78, checksum 08 → one `mem_we` pulse at addr 0 with data 0x12345678; `done`=1, `error`=0; exactly 7 cycles from `start` to `done`.
- Load `len`=2 with words 0x11223344 and 0xAABBCCDD, checksum 00 → writes at addr 0 then addr 1; `done`=1, `error`=1 (expected checksum 0x00^…= 0x44^0xDD… computed by the bench). Repeat with the correct checksum → `error`=0.
- `byte_valid` toggled randomly (about 50%) during a `len`=3 load → identical written words and addresses as with no stalls; no byte lost or duplicated; `mem_we` count = 3.
- `len`=0 → `done`=1 the cycle after `start`, no `mem_we`, no byte consumed, `byte_ready` never high. `len`=300 → exactly 256 writes, the last at `BASE_ADDR`+255.
- `reset_n` pulled low after 6 bytes of a `len`=4 load → all outputs return to reset values immediately; word 0 was written, word 1 never written; a fresh `start` reloads from addr 0.
- `start` pulsed mid-load → ignored, the load completes normally. `start` pulsed in DONE → `done` and `error` clear and a new load begins.
